alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU. WIDTH-bit signed operands, same opcode map for the single-cycle ops.
- Adds iterative signed multiply and divide, registered results and a correct result-based flag set.
- Sits between the datapath register file and the writeback stage. Both sides use valid/ready.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A, signed two's complement
- b  in  WIDTH  operand B, signed two's complement
- alu_sel  in  4  opcode
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  primary result (low product half / quotient)
- result_hi  out  WIDTH  high product half / remainder; 0 for other ops
- flag_z  out  1  result == 0 (and result_hi == 0 for MUL)
- flag_n  out  1  MSB of the final result (result_hi MSB for MUL)
- flag_c  out  1  carry (ADD) / unsigned borrow (SUB); 0 otherwise
- flag_v  out  1  signed overflow (ADD/SUB); 0 otherwise
- flag_err  out  1  illegal opcode or divide by zero

Behaviour:
- Opcodes:
  - 0001 ADD: {c,result} = a+b unsigned; v = signed overflow.
  - 0010 SUB: result = a-b; c = (a<b unsigned); v = signed overflow.
  - 0011 NOR.
  - 1011 SHL by 1.
  - 1100 SHR: logical, by 1.
  - 1000 SLT: signed, result 1/0.
  - 0110 EQ: result 1/0.
  - 0100 MUL: signed, 2*WIDTH product on {result_hi,result}.
  - 0101 DIV: signed, quotient truncated toward zero; remainder takes the dividend's sign.
  - Others: all outputs 0, err=1.
- Reset (async, any state): state=IDLE, out_valid=0, all result/flag outputs 0, counter 0. in_ready=1 after reset release.
- FSM states: IDLE, CALC, DONE.
  - Transfer happens when in_valid&&in_ready at a rising edge.
- IDLE transitions:
  - On transfer of a single-cycle op (incl. illegal): compute, register outputs, go to DONE. out_valid=1 the cycle after transfer (latency 1).
  - On transfer of MUL/DIV: latch |a|, |b| and the sign info, counter=0, go to CALC.
  - DIV with b==0: skip CALC and go to DONE with latency 1. result=all ones, result_hi=a, err=1, z/n computed from those values.
- CALC:
  - One shift-add (MUL) or restoring-subtract (DIV) step per cycle, WIDTH steps.
  - On the WIDTH-th step, apply sign correction (two's complement negate where required) and go to DONE.
  - out_valid rises exactly WIDTH+1 cycles after transfer.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; outputs held stable until out_valid&&out_ready.
  - in_ready = out_ready. A simultaneous accept plus new transfer starts the next op the same edge (back-to-back, no bubble for single-cycle ops).
  - On accept without a new transfer: go to IDLE, out_valid=0, outputs keep last values.
- in_ready=1 in IDLE regardless of out_ready.
- Most-negative edge cases:
  - MUL (-2^(W-1))*(-2^(W-1)) = +2^(2W-2), exact in 2W bits.
  - DIV (-2^(W-1))/(-1) wraps to -2^(W-1) with remainder 0, err=0.
- Operands and opcode are sampled only at transfer; later input changes have no effect.

Test Plan (WIDTH=8):
- ADD a=0x64, b=0x64 -> result=0xC8, v=1, c=0, n=1, z=0, out_valid 1 cycle after transfer. ADD 0xFF+0x01 -> result=0x00, c=1, z=1, v=0.
- MUL a=-7, b=9 -> {result_hi,result}=0xFFC1, n=1; out_valid exactly 9 cycles after transfer; in_ready=0 throughout CALC. MUL 0x80*0x80 -> 0x4000.
- DIV a=-7, b=2 -> result=0xFD, result_hi=0xFF, latency 9. DIV a=5, b=0 -> result=0xFF, result_hi=0x05, err=1, latency 1.
- Backpressure: ADD 3+4 with out_ready=0 for 3 cycles -> result=0x07 and flags held, out_valid=1, in_ready=0. Then out_ready=1 with an in_valid SUB 3-4 in the same cycle -> next cycle result=0xFF, c=1, n=1.
- rst_n low during cycle 4 of a MUL -> all outputs 0 immediately (async). After release: in_ready=1, out_valid=0, and the next ADD 1+1 returns 0x02.
- Illegal opcode 1111 -> result=0, result_hi=0, all flags 0 except err=1, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked signed ALU: single-cycle logic/arith ops plus iterative signed
// multiply (shift-add) and divide (restoring), all results registered.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_EQ  = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_rem;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic             xfer;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign xfer     = in_valid && in_ready;

    // Single-cycle datapath, evaluated on the live inputs at transfer
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_c;
    logic             sc_v;
    logic             sc_err;
    logic             sc_illegal;
    logic             sc_multi;
    logic             sc_z;
    logic             sc_n;

    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        sc_lo      = '0;
        sc_hi      = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_err     = 1'b0;
        sc_illegal = 1'b0;
        sc_multi   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                sc_lo = sum[WIDTH-1:0];
                sc_c  = sum[WIDTH];
                sc_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = diff[WIDTH-1:0];
                sc_c  = diff[WIDTH];
                sc_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR: sc_lo = ~(a | b);
            OP_SHL: sc_lo = {a[WIDTH-2:0], 1'b0};
            OP_SHR: sc_lo = {1'b0, a[WIDTH-1:1]};
            OP_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  sc_lo = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_MUL: sc_multi = 1'b1;
            OP_DIV: begin
                if (b == '0) begin
                    sc_lo  = '1;
                    sc_hi  = a;
                    sc_err = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            default: begin
                sc_err     = 1'b1;
                sc_illegal = 1'b1;
            end
        endcase
        // An illegal opcode reports only err, so z is suppressed too
        sc_z = !sc_illegal && (sc_lo == '0);
        sc_n = !sc_illegal && sc_lo[WIDTH-1];
    end

    // Operand magnitudes; |most-negative| fits as an unsigned WIDTH value
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // One iteration step for each of the two long ops
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opnd};
        if (is_div) begin
            step_hi = div_ge ? (div_sh - {1'b0, opnd}) : div_sh;
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the final step's output
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic               fin_z;
    logic               fin_n;

    always_comb begin
        prod = neg_lo ? -{step_hi[WIDTH-1:0], step_lo} : {step_hi[WIDTH-1:0], step_lo};
        if (is_div) begin
            fin_lo = neg_lo  ? -step_lo : step_lo;
            fin_hi = neg_rem ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
            fin_z  = (fin_lo == '0);
            fin_n  = fin_lo[WIDTH-1];
        end else begin
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_z  = (prod == '0);
            fin_n  = prod[2*WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_rem   <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
        end else if (xfer) begin
            // Transfer from IDLE or from DONE with a simultaneous accept
            if (sc_multi) begin
                state     <= S_CALC;
                out_valid <= 1'b0;
                cnt       <= '0;
                is_div    <= (alu_sel == OP_DIV);
                neg_lo    <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_rem   <= a[WIDTH-1];
                acc_hi    <= '0;
                acc_lo    <= (alu_sel == OP_DIV) ? a_mag : b_mag;
                opnd      <= (alu_sel == OP_DIV) ? b_mag : a_mag;
            end else begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                result    <= sc_lo;
                result_hi <= sc_hi;
                flag_z    <= sc_z;
                flag_n    <= sc_n;
                flag_c    <= sc_c;
                flag_v    <= sc_v;
                flag_err  <= sc_err;
            end
        end else begin
            case (state)
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= fin_lo;
                        result_hi <= fin_hi;
                        flag_z    <= fin_z;
                        flag_n    <= fin_n;
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        flag_err  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
